// File: rtl/gw2a_ddr_rdcal.sv
// Purpose: read-capture word-alignment calibrator; trains every DQ lane's IDES4 CALIB until it captures PATTERN.
// Latency: start -> rd_req next cycle; last beat -> EVAL next cycle -> calib/done/error/rd_req one cycle later.
// Backpressure: rd_req is held until rd_ack; beats are consumed only when rd_valid is high, with gaps allowed.
module gw2a_ddr_rdcal #(
    parameter int         WIDTH     = 16,
    parameter logic [7:0] PATTERN   = 8'h5A,
    parameter int         CONFIRM   = 2,
    parameter int         MAX_TRIES = 8,
    parameter int         SETTLE    = 4
) (
    input  logic               PCLK,
    input  logic               RESETN,
    input  logic               start,
    output logic               rd_req,
    input  logic               rd_ack,
    input  logic               rd_valid,
    input  logic [2*WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0]   calib,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [WIDTH-1:0]   locked,
    output logic [3:0]         tries
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_CAPT, S_EVAL, S_PULSE, S_WAIT, S_DONE, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         beat_q;
    logic [WIDTH-1:0]   mism_q;
    logic [1:0]         pass_q [WIDTH];
    logic [3:0]         settle_q;
    logic [WIDTH-1:0]   calib_q;

    logic               start_take;
    logic               beat_vld;
    logic [1:0]         exp_pair;
    logic [WIDTH-1:0]   fail_v;
    logic [WIDTH-1:0]   lock_new;
    logic               all_locked;
    logic [3:0]         tries_inc;

    // Qualify control events: start only when quiescent; a beat counts in CAPT or alongside the accepting rd_ack
    always_comb begin
        start_take = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
        beat_vld   = rd_valid && (state_q == S_CAPT || (state_q == S_REQ && rd_ack));
        exp_pair   = PATTERN[{beat_q, 1'b0} +: 2];
    end

    // Per-lane verdict of the read just captured; only meaningful while in EVAL
    always_comb begin
        fail_v   = '0;
        lock_new = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!locked[i]) begin
                if (mism_q[i]) begin
                    fail_v[i] = 1'b1;
                end else if (2'(pass_q[i] + 2'd1) == 2'(CONFIRM)) begin
                    lock_new[i] = 1'b1;
                end
            end
        end
        all_locked = &(locked | lock_new);
        tries_inc  = (tries == 4'd15) ? 4'd15 : tries + 4'd1;
    end

    // State register
    always_ff @(posedge PCLK) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; EVAL priority is lock, then exhaustion, then pulse, then confirmation read
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: if (start) state_d = S_REQ;
            S_REQ:   if (rd_ack) state_d = S_CAPT;
            S_CAPT:  if (rd_valid && beat_q == 2'd3) state_d = S_EVAL;
            S_EVAL: begin
                if (all_locked)                     state_d = S_DONE;
                else if (tries_inc == 4'(MAX_TRIES)) state_d = S_FAIL;
                else if (|fail_v)                   state_d = S_PULSE;
                else                                state_d = S_REQ;
            end
            S_PULSE: state_d = S_WAIT;
            S_WAIT:  if (settle_q == 4'(SETTLE - 1)) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: beat counting, sticky mismatches, pass counters, lock flags, tries and the calib strobe
    always_ff @(posedge PCLK) begin
        if (!RESETN) begin
            beat_q   <= '0;
            mism_q   <= '0;
            settle_q <= '0;
            calib_q  <= '0;
            locked   <= '0;
            tries    <= '0;
            for (int i = 0; i < WIDTH; i++) pass_q[i] <= '0;
        end else begin
            if (start_take) begin
                beat_q <= '0;
                mism_q <= '0;
                locked <= '0;
                tries  <= '0;
                for (int i = 0; i < WIDTH; i++) pass_q[i] <= '0;
            end
            if (beat_vld) begin
                beat_q <= beat_q + 2'd1;
                for (int i = 0; i < WIDTH; i++) begin
                    if (!locked[i] && rd_data[2*i +: 2] != exp_pair) mism_q[i] <= 1'b1;
                end
            end
            if (state_q == S_EVAL) begin
                tries  <= tries_inc;
                mism_q <= '0;
                locked <= locked | lock_new;
                for (int i = 0; i < WIDTH; i++) begin
                    if (!locked[i]) pass_q[i] <= mism_q[i] ? 2'd0 : pass_q[i] + 2'd1;
                end
            end
            // Marks live only for the single PULSE cycle; a FAIL verdict never pulses
            calib_q  <= (state_q == S_EVAL && state_d == S_PULSE) ? fail_v : '0;
            settle_q <= (state_q == S_WAIT) ? settle_q + 4'd1 : 4'd0;
        end
    end

    // Output decode from the state register
    always_comb begin
        rd_req = (state_q == S_REQ);
        busy   = (state_q == S_REQ) || (state_q == S_CAPT) || (state_q == S_EVAL) ||
                 (state_q == S_PULSE) || (state_q == S_WAIT);
        done   = (state_q == S_DONE);
        error  = (state_q == S_FAIL);
        calib  = calib_q;
    end

endmodule

// File: tb/tb_gw2a_ddr_rdcal.sv
// Purpose: randomized scoreboard bench for gw2a_ddr_rdcal with a lane-rotation memory model.
// Latency: expected calib/done/error events carry the cycle they must appear in.
// Backpressure: the responder stalls rd_ack and inserts gaps between rd_valid beats.
`timescale 1ns/1ps
module tb_gw2a_ddr_rdcal;
    localparam int         W    = 2;
    localparam int         DW   = 2 * W;
    localparam int         CONF = 2;
    localparam int         MAXT = 8;
    localparam int         SETL = 4;
    localparam logic [7:0] PAT  = 8'h5A;

    logic          PCLK = 1'b0;
    logic          RESETN = 1'b0;
    logic          start = 1'b0;
    logic          rd_ack = 1'b0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          rd_req, busy, done, error;
    logic [W-1:0]  calib, locked;
    logic [3:0]    tries;

    gw2a_ddr_rdcal #(.WIDTH(W), .PATTERN(PAT), .CONFIRM(CONF), .MAX_TRIES(MAXT), .SETTLE(SETL)) dut (
        .PCLK(PCLK), .RESETN(RESETN), .start(start), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .calib(calib), .busy(busy), .done(done),
        .error(error), .locked(locked), .tries(tries)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expected DUT event did not occur (cycle %0d)", name, cyc);
    endtask

    // Scoreboard entries: a calib pulse or a final done/error status, each with its due cycle
    typedef struct {
        bit           fin;
        logic [W-1:0] vec;
        logic         dn;
        logic         er;
        logic [W-1:0] lk;
        logic [3:0]   tr;
        int           at;
    } ev_t;
    ev_t exp_q[$];

    // Lane environment: each lane's captured word is PATTERN rotated by its offset; each calib advances it
    int   init_off [W];
    bit   stuck [W];
    int   pulses_seen [W];
    int   base [W];
    logic [7:0] wd [W];

    function automatic logic [7:0] rot8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} >> n;
        return d[7:0];
    endfunction

    function automatic logic [7:0] lane_word(input int i);
        if (stuck[i]) return 8'h00;
        return rot8(PAT, (init_off[i] + pulses_seen[i] - base[i]) % 8);
    endfunction

    function automatic logic [DW-1:0] beat_dat(input int b);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < W; i++) d[2*i +: 2] = wd[i][2*b +: 2];
        return d;
    endfunction

    // Monitor: pops the scoreboard whenever calib pulses or done/error rises
    ev_t          mev;
    logic [W-1:0] prev_cal = '0;
    logic         prev_fin = 1'b0;
    initial begin : monitor
        for (int i = 0; i < W; i++) pulses_seen[i] = 0;
        forever begin
            @(negedge PCLK);
            if (calib !== '0 && calib !== 'x) begin
                chk("calib_on_locked_lane", calib & locked, 0);
                chk("calib_back_to_back", prev_cal, 0);
                if (exp_q.size() == 0) begin
                    chk("calib_unexpected", calib, 0);
                end else begin
                    mev = exp_q.pop_front();
                    chk("calib_event_kind", mev.fin, 0);
                    chk("calib_lanes", calib, mev.vec);
                    chk("calib_cycle", cyc, mev.at);
                end
                for (int i = 0; i < W; i++) if (calib[i]) pulses_seen[i]++;
            end
            if ((done === 1'b1 || error === 1'b1) && !prev_fin) begin
                if (exp_q.size() == 0) begin
                    chk("final_unexpected", {done, error}, 0);
                end else begin
                    mev = exp_q.pop_front();
                    chk("final_event_kind", mev.fin, 1);
                    chk("final_done", done, mev.dn);
                    chk("final_error", error, mev.er);
                    chk("final_locked", locked, mev.lk);
                    chk("final_tries", tries, mev.tr);
                    chk("final_busy", busy, 0);
                    chk("final_cycle", cyc, mev.at);
                end
            end
            prev_cal = calib;
            prev_fin = (done === 1'b1) || (error === 1'b1);
        end
    end

    // Reference model of the calibration rules, one step per completed training read
    bit m_lk [W];
    int m_pass [W];
    int m_tries;
    int exp_rise;

    // Responder knobs
    int k_dmin, k_dmax, k_gmin, k_gmax;
    bit k_coin, k_inj;

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_calib"}, calib, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_tries"}, tries, 0);
    endtask

    task automatic do_start();
        int s;
        @(negedge PCLK);
        rd_ack = 0; rd_valid = 0; start = 1;
        s = cyc;
        @(negedge PCLK);
        start = 0;
        exp_rise = s + 1;
        m_tries = 0;
        for (int i = 0; i < W; i++) begin
            m_lk[i] = 0; m_pass[i] = 0; base[i] = pulses_seen[i];
        end
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_error_clr", error, 0);
        chk("start_locked_clr", locked, 0);
        chk("start_tries_clr", tries, 0);
    endtask

    task automatic serve(input bit abort_in_wait);
        int n, d, g, b, last;
        logic [W-1:0] mark;
        bit allk;
        ev_t ev;
        for (int r = 0; r < 16; r++) begin
            n = 0;
            while (rd_req !== 1'b1 && n < 200) begin
                rd_valid = ($urandom_range(0, 3) == 0);
                rd_data  = DW'($urandom);
                @(negedge PCLK);
                n++;
            end
            rd_valid = 0;
            if (rd_req !== 1'b1) begin
                fail_now("rd_req_timeout");
                return;
            end
            chk("rd_req_rise_cycle", cyc, exp_rise);
            for (int i = 0; i < W; i++) wd[i] = lane_word(i);
            d = $urandom_range(k_dmin, k_dmax);
            for (int j = 0; j < d; j++) begin
                rd_ack = 0;
                start = k_inj && (j == 1);
                @(negedge PCLK);
                start = 0;
                chk("rd_req_held", rd_req, 1);
            end
            rd_ack = 1;
            b = 0;
            if (k_coin && $urandom_range(0, 1) == 1) begin
                rd_valid = 1; rd_data = beat_dat(0); b = 1;
            end
            @(negedge PCLK);
            rd_ack = 0; rd_valid = 0;
            chk("rd_req_drop", rd_req, 0);
            while (b < 4) begin
                g = $urandom_range(k_gmin, k_gmax);
                for (int j = 0; j < g; j++) begin
                    rd_valid = 0; rd_data = DW'($urandom);
                    @(negedge PCLK);
                end
                rd_valid = 1; rd_data = beat_dat(b);
                @(negedge PCLK);
                b++;
            end
            rd_valid = 0;
            last = cyc;

            m_tries = (m_tries < 15) ? m_tries + 1 : 15;
            mark = '0;
            allk = 1;
            for (int i = 0; i < W; i++) begin
                if (!m_lk[i]) begin
                    if (wd[i] == PAT) begin
                        m_pass[i]++;
                        if (m_pass[i] >= CONF) m_lk[i] = 1;
                    end else begin
                        m_pass[i] = 0;
                        mark[i] = 1'b1;
                    end
                end
                if (!m_lk[i]) allk = 0;
            end
            ev.vec = mark; ev.at = last + 1; ev.tr = 4'(m_tries);
            for (int i = 0; i < W; i++) ev.lk[i] = m_lk[i];
            if (allk || m_tries == MAXT) begin
                ev.fin = 1; ev.dn = allk; ev.er = !allk;
                exp_q.push_back(ev);
                return;
            end else if (mark != '0) begin
                ev.fin = 0; ev.dn = 0; ev.er = 0;
                exp_q.push_back(ev);
                exp_rise = last + 1 + SETL + 1;
                if (abort_in_wait) begin
                    while (cyc < last + 2) @(negedge PCLK);
                    RESETN = 0;
                    @(negedge PCLK);
                    check_reset_outputs("wait_reset");
                    RESETN = 1;
                    return;
                end
            end else begin
                exp_rise = last + 1;
            end
        end
        fail_now("too_many_reads");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            @(negedge PCLK);
            n++;
        end
        if (exp_q.size() > 0) begin
            fail_now("scoreboard_event_timeout");
            exp_q.delete();
        end
    endtask

    task automatic set_knobs(input int dmin, input int dmax, input int gmin, input int gmax,
                             input bit coin, input bit inj);
        k_dmin = dmin; k_dmax = dmax; k_gmin = gmin; k_gmax = gmax; k_coin = coin; k_inj = inj;
    endtask

    task automatic set_lanes(input int o0, input int o1, input bit s0, input bit s1);
        init_off[0] = o0; init_off[1] = o1; stuck[0] = s0; stuck[1] = s1;
    endtask

    initial begin : main
        set_knobs(0, 2, 0, 1, 1, 0);
        set_lanes(0, 0, 0, 0);
        for (int i = 0; i < W; i++) base[i] = 0;
        RESETN = 0;
        repeat (3) @(negedge PCLK);
        check_reset_outputs("reset");
        RESETN = 1;

        // Aligned lanes lock after two reads with no calib
        do_start(); serve(0); drain();
        chk("aligned_done", done, 1);
        chk("aligned_locked", locked, 2'b11);
        chk("aligned_tries", tries, 2);

        // Lane 1 two bits off: two pulses on lane 1 only, done after four reads
        set_lanes(0, 6, 0, 0);
        do_start(); serve(0); drain();
        chk("shift_pulses_l1", pulses_seen[1] - base[1], 2);
        chk("shift_pulses_l0", pulses_seen[0] - base[0], 0);
        chk("shift_tries", tries, 4);

        // Lane 0 stuck at 00: MAX_TRIES reads, seven pulses, error
        set_lanes(0, 0, 1, 0);
        do_start(); serve(0); drain();
        chk("stuck_pulses_l0", pulses_seen[0] - base[0], 7);
        chk("stuck_error", error, 1);
        chk("stuck_locked", locked, 2'b10);
        chk("stuck_busy", busy, 0);

        // Stalled rd_ack, gapped beats and a start while busy give the same result
        set_knobs(5, 5, 1, 2, 0, 1);
        set_lanes(0, 6, 0, 0);
        do_start(); serve(0); drain();
        chk("stall_pulses_l1", pulses_seen[1] - base[1], 2);
        chk("stall_tries", tries, 4);
        chk("stall_done", done, 1);

        // Reset during WAIT, then a clean calibration
        set_knobs(0, 2, 0, 1, 1, 0);
        set_lanes(0, 6, 0, 0);
        do_start(); serve(1); drain();
        set_lanes(0, 0, 0, 0);
        do_start(); serve(0); drain();
        chk("post_reset_done", done, 1);
        chk("post_reset_tries", tries, 2);

        // Randomized lanes and handshake timing
        set_knobs(0, 5, 0, 2, 1, 0);
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < W; i++) begin
                init_off[i] = $urandom_range(0, 7);
                stuck[i]    = ($urandom_range(0, 5) == 0);
            end
            do_start(); serve(0); drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/gw2a_ddr_rdcal.md
# gw2a_ddr_rdcal

Read-capture word-alignment calibrator for the GW2A DDR I/O blocks. Sequences training reads through the memory controller, checks the deserialised `{Q1,Q0}` pairs of every DQ lane against a known pattern, and pulses each misaligned lane's IDES4 `CALIB` input until the lane captures the pattern on consecutive reads. Sits between the DDR PHY lanes and the controller's init sequencer. Runs once after PHY reset, and again whenever `start` is re-issued.

## Interface
Parameters:
- `WIDTH`, 16, number of DQ lanes (each lane is one DDR IOB).
- `PATTERN`, 8'h5A, expected training burst; beat k of every lane must equal `PATTERN[2k+1:2k]` as `{Q1,Q0}`, for k = 0..3.
- `CONFIRM`, 2, consecutive passing reads required to lock a lane (range 1..3).
- `MAX_TRIES`, 8, maximum training reads before failure (range 1..15).
- `SETTLE`, 4, idle PCLK cycles after a `CALIB` pulse before the next read (range 1..15).

Ports:
- `PCLK` in 1: bus clock, the same PCLK as the DDR IOBs; the only clock.
- `RESETN` in 1: synchronous, active-low reset.
- `start` in 1: pulse that begins or restarts calibration; sampled only in IDLE, DONE and FAIL.
- `rd_req` out 1: training-read request to the controller.
- `rd_ack` in 1: controller accepts the request.
- `rd_valid` in 1: one capture beat is present on `rd_data`.
- `rd_data` in 2*WIDTH: lane i is `rd_data[2i+1:2i]` = `{Q1,Q0}`.
- `calib` out WIDTH: per-lane IDES4 `CALIB` strobe.
- `busy` out 1: calibration in progress.
- `done` out 1: all lanes locked.
- `error` out 1: `MAX_TRIES` exhausted before every lane locked.
- `locked` out WIDTH: per-lane lock flags.
- `tries` out 4: number of training reads evaluated so far.

## Operation
- States: IDLE, REQ, CAPT, EVAL, PULSE, WAIT, DONE, FAIL.
- Start behaviour:
  - In IDLE, DONE or FAIL, `start` clears `locked`, `tries`, the per-lane pass counters and all mismatch flags, clears `done` and `error`, then goes to REQ.
  - `start` is ignored in every other state.
- REQ: `rd_req`=1 and held until `rd_ack`=1 is sampled. The state then moves to CAPT and `rd_req` drops on the following cycle.
- CAPT:
  - A 2-bit beat counter advances on each `rd_valid`.
  - For each unlocked lane, a mismatch between its pair and the expected beat sets that lane's sticky mismatch flag.
  - After the 4th valid beat, go to EVAL.
  - `rd_valid` outside CAPT is ignored.
- EVAL (1 cycle):
  - `tries` increments, saturating at 15.
  - For each unlocked lane with a mismatch: clear its pass counter and mark it for a pulse.
  - For each unlocked lane without a mismatch: increment its pass counter; at `CONFIRM` the lane sets `locked`.
  - Locked lanes are never modified again until the next `start`.
  - Next state, in priority order:
    - all lanes locked (including lanes that lock this cycle) -> DONE;
    - otherwise `tries` (post-increment) == `MAX_TRIES` -> FAIL;
    - otherwise any lane marked for a pulse -> PULSE;
    - otherwise -> REQ (confirmation read).
  - Mismatch flags clear on leaving EVAL.
- PULSE (1 cycle): `calib[i]`=1 for every marked lane. Marks clear. Go to WAIT.
- WAIT: count `SETTLE` cycles, then go to REQ.
- DONE: `done`=1, held. FAIL: `error`=1, held. Both hold until `start`.
- `busy`=1 in REQ, CAPT, EVAL, PULSE and WAIT.
- Each pulse rotates the lane's IDES4 word alignment by one bit. A healthy lane therefore locks within 4 pulses.

## Timing
- Reset (`RESETN`=0 at a PCLK edge): state IDLE; `rd_req`, `calib`, `busy`, `done`, `error`, `locked`, `tries` all 0; all internal counters and flags 0. Reset in any state aborts immediately, and the next cycle's outputs are the reset values.
- Outputs are registered.
- `start` at edge n -> `busy`=1 and `rd_req`=1 at edge n+1.
- `rd_ack` and `rd_valid` may arrive in the same cycle that `rd_req` rises. `rd_ack` may also coincide with the first `rd_valid`; that beat is counted.
- Last valid beat at edge m -> EVAL at m+1.
- EVAL decision at m+1 leads to one of:
  - `calib` high for exactly the cycle after m+1;
  - `done`/`error` high from m+2;
  - `rd_req` from m+2.
- After a pulse, `rd_req` re-asserts `SETTLE`+1 cycles after the `calib` cycle.
- `calib` is never asserted for a locked lane, and is never asserted for two consecutive cycles.

## Test plan
- Aligned lanes, WIDTH=2, CONFIRM=2: every read returns pairs 10,10,01,01 on both lanes -> no `calib`; `locked`=2'b11 and `done`=1 after read 2; `tries`=2.
- Lane 1 shifted by 2 bits, lane 0 aligned: model rotates lane 1 data on each `calib[1]` -> exactly 2 `calib[1]` pulses, no `calib[0]`, `done`=1 with `tries`=4.
- Lane 0 stuck at 00, MAX_TRIES=8 -> 8 reads, `calib[0]` pulsed 7 times, `error`=1, `locked`=2'b10, `busy`=0.
- `rd_ack` delayed 5 cycles, with gaps between `rd_valid` beats -> `rd_req` held for the full 5 cycles; only the 4 valid beats are compared; result is identical to the no-stall case.
- `start` re-issued while busy -> ignored. After `done`, re-issuing `start` -> `locked`, `tries` and `done` are cleared and the sequence reruns.
- `RESETN`=0 asserted during WAIT -> next cycle all outputs 0, state IDLE; a following `start` runs a clean calibration.
